rv_rsp_tag_resolver: RTL and testbench
======================================

Name: rv_rsp_tag_resolver

Overview:
- Downstream consumer of the tag allocator (index buffer). Memory responses return carrying the slot index allocated at request time.
- The block looks up that slot's stored request metadata and tracks which lanes of the request are still outstanding.
- It emits one registered, tagged response beat per accepted input beat. When the final beat is accepted, it releases the slot back to the allocator.

Parameters:
- SIZE, 4, number of tag slots; must match the allocator SIZE.
- ADDRW, $clog2(SIZE), tag width.
- DATAW, 8, metadata width held in the allocator table.
- NUM_LANES, 4, lanes per request.
- RSPW, 32, data bits per lane.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- expect_valid  in  1  slot just allocated; record its pending lanes.
- expect_tag  in  ADDRW  allocated slot index.
- expect_mask  in  NUM_LANES  lanes the request expects back.
- rsp_valid  in  1  response beat valid.
- rsp_tag  in  ADDRW  slot index of the beat.
- rsp_mask  in  NUM_LANES  lanes carried in this beat.
- rsp_data  in  NUM_LANES*RSPW  lane data; lane i occupies bits [i*RSPW +: RSPW].
- rsp_ready  out  1  beat accepted when rsp_valid && rsp_ready.
- lookup_addr  out  ADDRW  combinational, equals rsp_tag; drives the allocator read_addr.
- lookup_data  in  DATAW  same-cycle read data (combinational table read).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_tag  out  ADDRW  tag of the output beat.
- out_meta  out  DATAW  captured lookup_data.
- out_mask  out  NUM_LANES  lanes delivered (rsp_mask & pending).
- out_data  out  NUM_LANES*RSPW  captured rsp_data.
- out_eop  out  1  last beat of this request.
- release_slot  out  1  one-cycle pulse; frees the slot.
- release_addr  out  ADDRW  slot being freed.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, release_slot=0, err=0.
  - pending[*]=0; out_tag, out_meta, out_mask, out_data, out_eop and release_addr all 0.
- Accept condition:
  - rsp_ready = ~out_valid | out_ready, a single-entry output register with full throughput.
  - acc = rsp_valid & rsp_ready.
- Lane computation on acc:
  - hit = rsp_mask & pending[rsp_tag].
  - rem = pending[rsp_tag] & ~rsp_mask.
- Normal beat: acc and hit != 0.
  - Next edge: pending[rsp_tag] <= rem, out_valid <= 1.
  - Output register loads out_tag=rsp_tag, out_meta=lookup_data, out_mask=hit, out_data=rsp_data, out_eop=(rem==0).
- Latency: input-to-output is 1 cycle.
- Release:
  - If the accepted beat has rem==0, then on the same edge release_slot <= 1 and release_addr <= rsp_tag. This is coincident with the output beat's first valid cycle.
  - The pulse lasts exactly one cycle regardless of out_ready; metadata is already captured, so reusing the slot is safe.
- Stray beat: acc and hit == 0 (tag not pending).
  - Beat is consumed and dropped: no output, no release, err <= 1.
- Extra lanes: acc and (rsp_mask & ~pending[rsp_tag]) != 0.
  - err <= 1; the extra lanes are masked out of out_mask; the beat otherwise proceeds normally.
- Output hold:
  - out_valid && !out_ready keeps all out_* stable and deasserts rsp_ready.
  - out_valid clears when out_ready=1 and no new acc occurs.
- Expect:
  - expect_valid writes pending[expect_tag] <= expect_mask.
  - If pending[expect_tag] != 0 before the write, err <= 1 and the write still occurs.
  - expect_mask=0 is legal: the slot never produces output and is never released by this block.
- Simultaneous expect and response to the same tag: the expect write wins in pending[]. Response output and release still occur as computed from the old pending value. This covers release-then-immediate-reallocation.
- Simultaneous expect and response to different tags: both updates apply independently.
- err clears only on reset.
- Reset mid-operation discards the held output and all pending state. No release pulse is generated.

Decomposition:
- Shared package: lane-mask and tag typedefs sized from NUM_LANES and ADDRW; the lane-slice macro (i*RSPW +: RSPW).
- One natural sub-module: rv_rsp_pending_table. It holds the SIZE x NUM_LANES pending register array, with one write port for expect, one read-modify-write port for response clear (expect priority), and an async active-low clear.

Test Plan:
- expect tag=2 mask=4'b1111; rsp tag=2 mask=4'b1111, lookup_data=8'hA5 -> next cycle:
  - out_valid=1, out_tag=2, out_meta=A5, out_mask=1111, out_eop=1.
  - release_slot pulse with release_addr=2; pending[2]=0.
- expect tag=1 mask=1111; beats mask=0011 then 1100 -> first output eop=0 with no release; second output eop=1 with release_addr=1.
- Output stall: hold out_ready=0 with rsp_valid=1 -> rsp_ready=0 and out_* stable.
  - Raise out_ready -> the next beat is accepted in the same cycle; back-to-back outputs with no bubble.
- Stray and extra lanes:
  - rsp tag=3 with pending[3]=0 -> no out_valid, no release, err=1.
  - Separately, pending=0001 with rsp mask=0011 -> out_mask=0001, eop=1, err=1.
- Same-cycle reallocation: tag 0 pending=1000; rsp tag=0 mask=1000 while expect tag=0 mask=0110 -> release_addr=0 pulses and pending[0]=0110 afterwards; err stays 0.
- Reset mid-operation: assert reset=0 while out_valid=1 and pending is nonzero -> out_valid=0, release_slot=0, err=0 asynchronously.
  - After deassertion, a rsp to a previously pending tag flags err.

Source files
------------

// File: rtl/rv_rsp_tag_resolver_pkg.sv
// rv_rsp_tag_resolver_pkg
//   Shared types and defaults for the response tag resolver slice.
//   - SIZE_DEF / ADDRW_DEF : tag slot count and tag width
//   - NUM_LANES_DEF        : lanes per request
//   - DATAW_DEF / RSPW_DEF : metadata width and data bits per lane
//   - lane_mask_t / tag_t  : lane-mask and tag types at the default sizes
//   - RV_LANE_SLICE(i, w)  : part-select for lane i of a packed lane bus
package rv_rsp_tag_resolver_pkg;

   localparam int unsigned SIZE_DEF      = 4;
   localparam int unsigned ADDRW_DEF     = $clog2(SIZE_DEF);
   localparam int unsigned DATAW_DEF     = 8;
   localparam int unsigned NUM_LANES_DEF = 4;
   localparam int unsigned RSPW_DEF      = 32;

   typedef logic [NUM_LANES_DEF-1:0] lane_mask_t;
   typedef logic [ADDRW_DEF-1:0]     tag_t;

endpackage

`define RV_LANE_SLICE(i, w) ((i)*(w)) +: (w)

// File: rtl/rv_rsp_pending_table.sv
// rv_rsp_pending_table
//   SIZE x NUM_LANES register array of lanes still outstanding per tag.
//   Ports:
//     clk, reset             clock, asynchronous active-low clear
//     wr_en/wr_addr/wr_mask  expect write port (wins over the clear port)
//     wr_old                 current contents at wr_addr
//     rd_addr/rd_mask        combinational read for the response lookup
//     clr_en/clr_lanes       read-modify-write: pending[rd_addr] &= ~clr_lanes
module rv_rsp_pending_table
   import rv_rsp_tag_resolver_pkg::*;
#(
   parameter int unsigned SIZE      = SIZE_DEF,
   parameter int unsigned ADDRW     = $clog2(SIZE),
   parameter int unsigned NUM_LANES = NUM_LANES_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [ADDRW-1:0]     wr_addr,
   input  logic [NUM_LANES-1:0] wr_mask,
   output logic [NUM_LANES-1:0] wr_old,
   input  logic [ADDRW-1:0]     rd_addr,
   output logic [NUM_LANES-1:0] rd_mask,
   input  logic                 clr_en,
   input  logic [NUM_LANES-1:0] clr_lanes
);

   logic [NUM_LANES-1:0] pending [SIZE];

   assign rd_mask = pending[rd_addr];
   assign wr_old  = pending[wr_addr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < SIZE; i++) pending[i] <= '0;
      end else begin
         if (clr_en) pending[rd_addr] <= pending[rd_addr] & ~clr_lanes;
         // Later assignment wins, so an expect to the same tag overrides the clear.
         if (wr_en)  pending[wr_addr] <= wr_mask;
      end
   end

endmodule

// File: rtl/rv_rsp_tag_resolver.sv
// rv_rsp_tag_resolver
//   Resolves tagged memory response beats against the per-slot pending lane
//   masks, emits one registered output beat per useful input beat, and
//   pulses release_slot when the final lanes of a request arrive.
//   Ports:
//     clk, reset                          clock, asynchronous active-low reset
//     expect_valid/expect_tag/expect_mask record lanes for a newly allocated slot
//     rsp_valid/rsp_ready/rsp_tag/rsp_mask/rsp_data  response beat input
//     lookup_addr/lookup_data             combinational metadata table read
//     out_valid/out_ready/out_tag/out_meta/out_mask/out_data/out_eop  output beat
//     release_slot/release_addr           one-cycle slot free pulse
//     err                                 sticky protocol error
module rv_rsp_tag_resolver
   import rv_rsp_tag_resolver_pkg::*;
#(
   parameter int unsigned SIZE      = SIZE_DEF,
   parameter int unsigned ADDRW     = $clog2(SIZE),
   parameter int unsigned DATAW     = DATAW_DEF,
   parameter int unsigned NUM_LANES = NUM_LANES_DEF,
   parameter int unsigned RSPW      = RSPW_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      expect_valid,
   input  logic [ADDRW-1:0]          expect_tag,
   input  logic [NUM_LANES-1:0]      expect_mask,
   input  logic                      rsp_valid,
   input  logic [ADDRW-1:0]          rsp_tag,
   input  logic [NUM_LANES-1:0]      rsp_mask,
   input  logic [NUM_LANES*RSPW-1:0] rsp_data,
   output logic                      rsp_ready,
   output logic [ADDRW-1:0]          lookup_addr,
   input  logic [DATAW-1:0]          lookup_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ADDRW-1:0]          out_tag,
   output logic [DATAW-1:0]          out_meta,
   output logic [NUM_LANES-1:0]      out_mask,
   output logic [NUM_LANES*RSPW-1:0] out_data,
   output logic                      out_eop,
   output logic                      release_slot,
   output logic [ADDRW-1:0]          release_addr,
   output logic                      err
);

   logic [NUM_LANES-1:0] cur, hit, rem, wr_old, exp_prior;
   logic                 acc, normal, last, beat_err, exp_err;

   rv_rsp_pending_table #(
      .SIZE      (SIZE),
      .ADDRW     (ADDRW),
      .NUM_LANES (NUM_LANES)
   ) u_pending (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (expect_valid),
      .wr_addr   (expect_tag),
      .wr_mask   (expect_mask),
      .wr_old    (wr_old),
      .rd_addr   (rsp_tag),
      .rd_mask   (cur),
      .clr_en    (normal),
      .clr_lanes (rsp_mask)
   );

   assign rsp_ready   = ~out_valid | out_ready;
   assign lookup_addr = rsp_tag;

   always_comb begin
      acc      = rsp_valid & rsp_ready;
      hit      = rsp_mask & cur;
      rem      = cur & ~rsp_mask;
      normal   = acc & (|hit);
      last     = normal & ~(|rem);
      beat_err = acc & (~(|hit) | (|(rsp_mask & ~cur)));
      // A same-tag expect sees the slot as already cleared by the accepted beat,
      // so release-then-reallocate in one cycle is not an overwrite error.
      exp_prior = (normal && (rsp_tag == expect_tag)) ? rem : wr_old;
      exp_err   = expect_valid & (|exp_prior);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid    <= 1'b0;
         out_tag      <= '0;
         out_meta     <= '0;
         out_mask     <= '0;
         out_data     <= '0;
         out_eop      <= 1'b0;
         release_slot <= 1'b0;
         release_addr <= '0;
         err          <= 1'b0;
      end else begin
         release_slot <= last;
         if (last) release_addr <= rsp_tag;
         if (rsp_ready) out_valid <= normal;
         if (normal) begin
            out_tag  <= rsp_tag;
            out_meta <= lookup_data;
            out_mask <= hit;
            out_data <= rsp_data;
            out_eop  <= ~(|rem);
         end
         if (beat_err || exp_err) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rv_rsp_tag_resolver.sv
// tb_rv_rsp_tag_resolver
//   Directed scenarios plus randomized traffic against a transaction-level
//   model of the pending-lane bookkeeping.
module tb_rv_rsp_tag_resolver;
   import rv_rsp_tag_resolver_pkg::*;

   localparam int SIZE = 4, ADDRW = 2, DATAW = 8, NL = 4, RSPW = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              expect_valid;
   tag_t              expect_tag;
   lane_mask_t        expect_mask;
   logic              rsp_valid;
   tag_t              rsp_tag;
   lane_mask_t        rsp_mask;
   logic [NL*RSPW-1:0] rsp_data;
   logic              rsp_ready;
   tag_t              lookup_addr;
   logic [DATAW-1:0]  lookup_data;
   logic              out_valid;
   logic              out_ready;
   tag_t              out_tag;
   logic [DATAW-1:0]  out_meta;
   lane_mask_t        out_mask;
   logic [NL*RSPW-1:0] out_data;
   logic              out_eop;
   logic              release_slot;
   tag_t              release_addr;
   logic              err;

   logic [DATAW-1:0]  meta_tbl [SIZE];
   logic [19:0]       obs;

   always #5 clk = ~clk;

   assign lookup_data = meta_tbl[lookup_addr];
   assign obs = {out_valid, out_tag, out_meta, out_mask, out_eop, release_slot, release_addr, err};

   rv_rsp_tag_resolver #(
      .SIZE      (SIZE),
      .ADDRW     (ADDRW),
      .DATAW     (DATAW),
      .NUM_LANES (NL),
      .RSPW      (RSPW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .expect_valid (expect_valid),
      .expect_tag   (expect_tag),
      .expect_mask  (expect_mask),
      .rsp_valid    (rsp_valid),
      .rsp_tag      (rsp_tag),
      .rsp_mask     (rsp_mask),
      .rsp_data     (rsp_data),
      .rsp_ready    (rsp_ready),
      .lookup_addr  (lookup_addr),
      .lookup_data  (lookup_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_tag      (out_tag),
      .out_meta     (out_meta),
      .out_mask     (out_mask),
      .out_data     (out_data),
      .out_eop      (out_eop),
      .release_slot (release_slot),
      .release_addr (release_addr),
      .err          (err)
   );

   // ---------------- reference model ----------------
   lane_mask_t        m_pend [SIZE];
   logic              m_ov, m_eop, m_rel, m_err;
   tag_t              m_tag, m_rel_addr;
   logic [DATAW-1:0]  m_meta;
   lane_mask_t        m_mask;
   logic [NL*RSPW-1:0] m_data;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [19:0] m_obs();
      return {m_ov, m_tag, m_meta, m_mask, m_eop, m_rel, m_rel_addr, m_err};
   endfunction

   function automatic logic [NL*RSPW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < SIZE; i++) m_pend[i] = '0;
      m_ov = 0; m_eop = 0; m_rel = 0; m_err = 0;
      m_tag = '0; m_rel_addr = '0; m_meta = '0; m_mask = '0; m_data = '0;
   endtask

   // Predicts the state after the coming edge from the current inputs, then clocks.
   task automatic cycle();
      lane_mask_t        np [SIZE];
      lane_mask_t        p;
      logic              rdy, nov, neop, nrel, nerr;
      tag_t              ntag, nra;
      logic [DATAW-1:0]  nmeta;
      lane_mask_t        nmask;
      logic [NL*RSPW-1:0] ndata;
      np = m_pend;
      rdy = !m_ov || out_ready;
      nov = m_ov; neop = m_eop; nrel = 0; nerr = m_err;
      ntag = m_tag; nra = m_rel_addr; nmeta = m_meta; nmask = m_mask; ndata = m_data;
      if (rdy) nov = 0;
      if (rsp_valid && rdy) begin
         p = np[rsp_tag];
         if ((rsp_mask & p) == 0 || (rsp_mask & ~p) != 0) nerr = 1;
         if ((rsp_mask & p) != 0) begin
            nov = 1; ntag = rsp_tag; nmeta = meta_tbl[rsp_tag];
            nmask = rsp_mask & p; ndata = rsp_data;
            neop = ((p & ~rsp_mask) == 0);
            np[rsp_tag] = p & ~rsp_mask;
            if (neop) begin nrel = 1; nra = rsp_tag; end
         end
      end
      if (expect_valid) begin
         if (np[expect_tag] != 0) nerr = 1;
         np[expect_tag] = expect_mask;
      end
      @(posedge clk);
      m_pend = np; m_ov = nov; m_eop = neop; m_rel = nrel; m_err = nerr;
      m_tag = ntag; m_rel_addr = nra; m_meta = nmeta; m_mask = nmask; m_data = ndata;
      #1;
   endtask

   task automatic idle_inputs();
      expect_valid = 0; expect_tag = '0; expect_mask = '0;
      rsp_valid = 0; rsp_tag = '0; rsp_mask = '0; rsp_data = '0;
      out_ready = 1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 0;
      #2;
      reset = 1;
      model_reset();
   endtask

   task automatic do_expect(input tag_t t, input lane_mask_t m);
      idle_inputs();
      expect_valid = 1; expect_tag = t; expect_mask = m;
      cycle();
      expect_valid = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      reset = 0;
      #3;
      n_checks++; if (obs !== 20'h0 || out_data !== '0) begin n_fail++;
         $display("FAIL reset_state got obs=%h data=%h want 0", obs, out_data); end
      n_checks++; if (rsp_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_rsp_ready got %b want 1", rsp_ready); end
      @(posedge clk); #1;
      reset = 1;
      model_reset();
   endtask

   task automatic test_single();
      logic [NL*RSPW-1:0] d;
      do_reset();
      meta_tbl[2] = 8'hA5;
      do_expect(2'd2, 4'b1111);
      d = rnd_data();
      rsp_valid = 1; rsp_tag = 2'd2; rsp_mask = 4'b1111; rsp_data = d;
      #1;
      n_checks++; if (rsp_ready !== 1'b1 || lookup_addr !== 2'd2) begin n_fail++;
         $display("FAIL single_lookup got rdy=%b addr=%0d want 1,2", rsp_ready, lookup_addr); end
      cycle();
      rsp_valid = 0;
      n_checks++; if (obs !== {1'b1, 2'd2, 8'hA5, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0}) begin n_fail++;
         $display("FAIL single_out got %h want %h", obs, {1'b1, 2'd2, 8'hA5, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0}); end
      n_checks++; if (out_data !== d) begin n_fail++;
         $display("FAIL single_data got %h want %h", out_data, d); end
      cycle();
      n_checks++; if ({out_valid, release_slot} !== 2'b00) begin n_fail++;
         $display("FAIL single_after got v=%b rel=%b want 0,0", out_valid, release_slot); end
      // slot 2 is now empty: a repeat beat must be a stray
      rsp_valid = 1; rsp_tag = 2'd2; rsp_mask = 4'b0001;
      cycle();
      rsp_valid = 0;
      n_checks++; if ({out_valid, release_slot, err} !== 3'b001) begin n_fail++;
         $display("FAIL single_cleared got v/rel/err=%b want 001", {out_valid, release_slot, err}); end
   endtask

   task automatic test_multi_beat();
      do_reset();
      do_expect(2'd1, 4'b1111);
      rsp_valid = 1; rsp_tag = 2'd1; rsp_mask = 4'b0011; rsp_data = rnd_data();
      cycle();
      n_checks++; if ({out_valid, out_mask, out_eop, release_slot} !== {1'b1, 4'b0011, 1'b0, 1'b0}) begin n_fail++;
         $display("FAIL multi_first got v=%b m=%b eop=%b rel=%b want 1,0011,0,0", out_valid, out_mask, out_eop, release_slot); end
      rsp_mask = 4'b1100; rsp_data = rnd_data();
      cycle();
      rsp_valid = 0;
      n_checks++; if ({out_valid, out_mask, out_eop, release_slot, release_addr, err} !== {1'b1, 4'b1100, 1'b1, 1'b1, 2'd1, 1'b0}) begin n_fail++;
         $display("FAIL multi_last got v=%b m=%b eop=%b rel=%b ra=%0d err=%b want 1,1100,1,1,1,0",
                  out_valid, out_mask, out_eop, release_slot, release_addr, err); end
      cycle();
   endtask

   task automatic test_stall();
      logic [NL*RSPW-1:0] d1, d2, d3;
      logic [19:0] held;
      do_reset();
      do_expect(2'd3, 4'b1111);
      do_expect(2'd0, 4'b1111);
      d1 = rnd_data(); d2 = rnd_data(); d3 = rnd_data();
      rsp_valid = 1; rsp_tag = 2'd3; rsp_mask = 4'b0011; rsp_data = d1;
      cycle();
      held = {1'b1, 2'd3, meta_tbl[3], 4'b0011, 1'b0, 1'b0, 2'd0, 1'b0};
      out_ready = 0; rsp_mask = 4'b1100; rsp_data = d2;
      #1;
      n_checks++; if (rsp_ready !== 1'b0) begin n_fail++;
         $display("FAIL stall_ready got %b want 0", rsp_ready); end
      for (int k = 0; k < 2; k++) begin
         cycle();
         n_checks++; if (obs !== held || out_data !== d1) begin n_fail++;
            $display("FAIL stall_hold got %h want %h", obs, held); end
      end
      out_ready = 1;
      #1;
      n_checks++; if (rsp_ready !== 1'b1) begin n_fail++;
         $display("FAIL stall_release_ready got %b want 1", rsp_ready); end
      cycle();
      n_checks++; if (obs !== {1'b1, 2'd3, meta_tbl[3], 4'b1100, 1'b1, 1'b1, 2'd3, 1'b0} || out_data !== d2) begin n_fail++;
         $display("FAIL stall_second got %h data=%h", obs, out_data); end
      rsp_tag = 2'd0; rsp_mask = 4'b1111; rsp_data = d3;
      cycle();
      rsp_valid = 0;
      n_checks++; if (obs !== {1'b1, 2'd0, meta_tbl[0], 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0} || out_data !== d3) begin n_fail++;
         $display("FAIL back_to_back got %h data=%h", obs, out_data); end
      cycle();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL stall_drain got %b want 0", out_valid); end
   endtask

   task automatic test_stray_extra();
      do_reset();
      rsp_valid = 1; rsp_tag = 2'd3; rsp_mask = 4'b1111; rsp_data = rnd_data();
      cycle();
      rsp_valid = 0;
      n_checks++; if ({out_valid, release_slot, err} !== 3'b001) begin n_fail++;
         $display("FAIL stray got v/rel/err=%b want 001", {out_valid, release_slot, err}); end
      do_reset();
      do_expect(2'd1, 4'b0001);
      rsp_valid = 1; rsp_tag = 2'd1; rsp_mask = 4'b0011; rsp_data = rnd_data();
      cycle();
      rsp_valid = 0;
      n_checks++; if ({out_valid, out_mask, out_eop, release_slot, release_addr, err} !== {1'b1, 4'b0001, 1'b1, 1'b1, 2'd1, 1'b1}) begin n_fail++;
         $display("FAIL extra_lanes got v=%b m=%b eop=%b rel=%b ra=%0d err=%b want 1,0001,1,1,1,1",
                  out_valid, out_mask, out_eop, release_slot, release_addr, err); end
   endtask

   task automatic test_realloc();
      do_reset();
      do_expect(2'd0, 4'b1000);
      rsp_valid = 1; rsp_tag = 2'd0; rsp_mask = 4'b1000; rsp_data = rnd_data();
      expect_valid = 1; expect_tag = 2'd0; expect_mask = 4'b0110;
      cycle();
      expect_valid = 0;
      n_checks++; if ({out_valid, out_mask, out_eop, release_slot, release_addr, err} !== {1'b1, 4'b1000, 1'b1, 1'b1, 2'd0, 1'b0}) begin n_fail++;
         $display("FAIL realloc_release got v=%b m=%b eop=%b rel=%b ra=%0d err=%b want 1,1000,1,1,0,0",
                  out_valid, out_mask, out_eop, release_slot, release_addr, err); end
      rsp_mask = 4'b0110;
      cycle();
      rsp_valid = 0;
      n_checks++; if ({out_valid, out_mask, out_eop, release_slot, err} !== {1'b1, 4'b0110, 1'b1, 1'b1, 1'b0}) begin n_fail++;
         $display("FAIL realloc_new got v=%b m=%b eop=%b rel=%b err=%b want 1,0110,1,1,0",
                  out_valid, out_mask, out_eop, release_slot, err); end
      cycle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      do_expect(2'd2, 4'b1111);
      do_expect(2'd1, 4'b1111);
      rsp_valid = 1; rsp_tag = 2'd3; rsp_mask = 4'b0001;   // stray to set err
      cycle();
      rsp_tag = 2'd1; rsp_mask = 4'b1111; rsp_data = rnd_data();
      cycle();
      rsp_valid = 0; out_ready = 0;
      n_checks++; if ({out_valid, release_slot, err} !== 3'b111) begin n_fail++;
         $display("FAIL mid_pre got v/rel/err=%b want 111", {out_valid, release_slot, err}); end
      #2;
      reset = 0;
      #1;
      n_checks++; if (obs !== 20'h0 || out_data !== '0) begin n_fail++;
         $display("FAIL mid_reset got obs=%h want 0", obs); end
      #1;
      reset = 1;
      model_reset();
      out_ready = 1;
      rsp_valid = 1; rsp_tag = 2'd2; rsp_mask = 4'b1111;
      cycle();
      rsp_valid = 0;
      n_checks++; if ({out_valid, release_slot, err} !== 3'b001) begin n_fail++;
         $display("FAIL mid_after got v/rel/err=%b want 001", {out_valid, release_slot, err}); end
   endtask

   task automatic test_random();
      tag_t t;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         idle_inputs();
         if ($urandom_range(15) == 0) meta_tbl[$urandom_range(SIZE-1)] = DATAW'($urandom);
         if ($urandom_range(3) == 0) begin
            t = ADDRW'($urandom_range(SIZE-1));
            if (m_pend[t] == 0 || $urandom_range(19) == 0) begin
               expect_valid = 1; expect_tag = t; expect_mask = NL'($urandom);
            end
         end
         if ($urandom_range(9) < 6) begin
            rsp_valid = 1;
            rsp_tag = ADDRW'($urandom_range(SIZE-1));
            rsp_mask = m_pend[rsp_tag] & NL'($urandom);
            if (rsp_mask == 0 || $urandom_range(19) == 0) rsp_mask = NL'($urandom);
            rsp_data = rnd_data();
         end
         out_ready = ($urandom_range(9) < 7);
         #1;
         n_checks++; if (rsp_ready !== (!m_ov || out_ready) || lookup_addr !== rsp_tag) begin n_fail++;
            $display("FAIL rand_ready[%0d] got rdy=%b addr=%0d want %b,%0d", n, rsp_ready, lookup_addr, (!m_ov || out_ready), rsp_tag); end
         cycle();
         n_checks++; if (obs !== m_obs() || (m_ov && out_data !== m_data)) begin n_fail++;
            $display("FAIL rand_out[%0d] got %h want %h", n, obs, m_obs()); end
      end
      idle_inputs();
   endtask

   initial begin
      for (int i = 0; i < SIZE; i++) meta_tbl[i] = DATAW'($urandom);
      model_reset();
      test_reset();
      test_single();
      test_multi_beat();
      test_stall();
      test_stray_extra();
      test_realloc();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
